// File: rtl/ascii_save_capture.sv
// ascii_save_capture: records the bytes the UK101 writes to its ACIA TX register into a block RAM and serves them to hps_io as an upload.
// Optional build macro SAVE_LF_INSERT_EN inserts 0x0A after each captured 0x0D.
module ascii_save_capture #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              capture_arm,
  input  logic              tx_wr,
  input  logic [7:0]        tx_data,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [15:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic [ADDR_W:0]   save_len,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_UPLOAD  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [7:0]          mem_r [2**ADDR_W];
  logic                arm_q_r, arm_rise_s, arm_fall_s;
  logic                stop_pend_r, stop_pend_nxt_s, stop_s;
  logic                wr_req_s, wr_ok_s, drop_s, drain_s, clear_s, req_nxt_s;
  logic [7:0]          wr_byte_s;
  logic [ADDR_W:0]     len_nxt_s;
  logic                rd_req_s, rd_inr_s;
  logic                out_v_s, out_in_s;
  logic [ADDR_W-1:0]   out_a_s;

  assign arm_rise_s = capture_arm & ~arm_q_r;
  assign arm_fall_s = ~capture_arm & arm_q_r;
  assign wr_ok_s    = wr_req_s & ~save_len[ADDR_W];
  assign drop_s     = wr_req_s & save_len[ADDR_W];
  assign len_nxt_s  = save_len + {{ADDR_W{1'b0}}, wr_ok_s};

`ifdef SAVE_LF_INSERT_EN
  localparam logic [7:0] CR_C = 8'h0D;
  logic       lf_pend_r, lf_pend_nxt_s, skid_v_r, skid_v_nxt_s;
  logic [7:0] skid_r, skid_nxt_s;

  // Write-slot arbitration: a pending LF goes first, then the skid byte, then a live tx_wr.
  always_comb begin
    wr_req_s      = 1'b0;
    wr_byte_s     = tx_data;
    lf_pend_nxt_s = 1'b0;
    skid_v_nxt_s  = 1'b0;
    skid_nxt_s    = skid_r;
    if (state_r == ST_CAPTURE) begin
      if (lf_pend_r) begin
        wr_req_s     = 1'b1;
        wr_byte_s    = 8'h0A;
        skid_v_nxt_s = tx_wr | skid_v_r;
        skid_nxt_s   = tx_wr ? tx_data : skid_r;
      end else if (skid_v_r) begin
        wr_req_s      = 1'b1;
        wr_byte_s     = skid_r;
        lf_pend_nxt_s = (skid_r == CR_C);
        skid_v_nxt_s  = tx_wr;
        skid_nxt_s    = tx_data;
      end else begin
        wr_req_s      = tx_wr;
        lf_pend_nxt_s = tx_wr && (tx_data == CR_C);
      end
    end else begin
      wr_req_s = 1'b0;
    end
  end

  assign drain_s = lf_pend_nxt_s | skid_v_nxt_s;

  // LF-insert and skid state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lf_pend_r <= 1'b0;
      skid_v_r  <= 1'b0;
      skid_r    <= 8'h00;
    end else begin
      lf_pend_r <= lf_pend_nxt_s;
      skid_v_r  <= skid_v_nxt_s;
      skid_r    <= skid_nxt_s;
    end
  end
`else
  assign wr_req_s  = (state_r == ST_CAPTURE) && tx_wr;
  assign wr_byte_s = tx_data;
  assign drain_s   = 1'b0;
`endif

  // Next state; a stop request waits until any inserted/skidded byte has been written.
  always_comb begin
    state_nxt_s     = state_r;
    stop_pend_nxt_s = 1'b0;
    req_nxt_s       = 1'b0;
    clear_s         = 1'b0;
    stop_s          = arm_fall_s | stop_pend_r;
    case (state_r)
      ST_IDLE: begin
        if (arm_rise_s) begin
          state_nxt_s = ST_CAPTURE;
          clear_s     = 1'b1;
        end else if (ioctl_upload) begin
          state_nxt_s = ST_UPLOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (stop_s && !drain_s) begin
          state_nxt_s = ST_HOLD;
          req_nxt_s   = (len_nxt_s != {(ADDR_W+1){1'b0}});
        end else begin
          stop_pend_nxt_s = stop_s;
        end
      end
      ST_HOLD: begin
        if (ioctl_upload) begin
          state_nxt_s = ST_UPLOAD;
        end else if (arm_rise_s) begin
          state_nxt_s = ST_CAPTURE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_UPLOAD: begin
        if (!ioctl_upload) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_UPLOAD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, arm edge detector and status outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      arm_q_r          <= 1'b0;
      stop_pend_r      <= 1'b0;
      ioctl_upload_req <= 1'b0;
      busy             <= 1'b0;
      save_len         <= {(ADDR_W+1){1'b0}};
      overflow         <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      arm_q_r          <= capture_arm;
      stop_pend_r      <= stop_pend_nxt_s;
      ioctl_upload_req <= req_nxt_s;
      busy             <= (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_UPLOAD);
      if (clear_s) begin
        save_len <= {(ADDR_W+1){1'b0}};
        overflow <= 1'b0;
      end else begin
        save_len <= len_nxt_s;
        overflow <= overflow | drop_s;
      end
    end
  end

  // Capture write port.
  always_ff @(posedge clk_sys) begin
    if (wr_ok_s) mem_r[save_len[ADDR_W-1:0]] <= wr_byte_s;
  end

  assign rd_req_s = (state_r == ST_UPLOAD) && ioctl_rd;
  assign rd_inr_s = (32'(ioctl_addr) < 32'(save_len));

  if (RD_LAT == 1) begin : g_lat1
    assign out_v_s  = rd_req_s;
    assign out_in_s = rd_inr_s;
    assign out_a_s  = ioctl_addr[ADDR_W-1:0];
  end else begin : g_latn
    logic [RD_LAT-2:0]             v_r, in_r;
    logic [RD_LAT-2:0][ADDR_W-1:0] a_r;

    // Request delay line; the RAM is read in the final stage.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        v_r  <= {(RD_LAT-1){1'b0}};
        in_r <= {(RD_LAT-1){1'b0}};
        a_r  <= {((RD_LAT-1)*ADDR_W){1'b0}};
      end else begin
        v_r[0]  <= rd_req_s;
        in_r[0] <= rd_inr_s;
        a_r[0]  <= ioctl_addr[ADDR_W-1:0];
        for (int i = 1; i < RD_LAT - 1; i++) begin
          v_r[i]  <= v_r[i-1];
          in_r[i] <= in_r[i-1];
          a_r[i]  <= a_r[i-1];
        end
      end
    end

    assign out_v_s  = v_r[RD_LAT-2];
    assign out_in_s = in_r[RD_LAT-2];
    assign out_a_s  = a_r[RD_LAT-2];
  end

  // Registered read port; data holds until the next read completes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_din <= 8'h00;
    end else if (state_r == ST_CAPTURE) begin
      ioctl_din <= 8'h00;
    end else if (out_v_s) begin
      ioctl_din <= out_in_s ? mem_r[out_a_s] : 8'h00;
    end
  end

endmodule

// File: tb/tb_ascii_save_capture.sv
// Directed bench for ascii_save_capture with a read-data scoreboard; honours SAVE_LF_INSERT_EN.
module tb_ascii_save_capture;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 2;
`ifdef SAVE_LF_INSERT_EN
  localparam bit LF = 1'b1;
`else
  localparam bit LF = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              capture_arm = 1'b0;
  logic              tx_wr = 1'b0;
  logic [7:0]        tx_data = 8'h00;
  logic              ioctl_upload = 1'b0;
  logic              ioctl_rd = 1'b0;
  logic [15:0]       ioctl_addr = 16'h0000;
  logic [7:0]        ioctl_din;
  logic              ioctl_upload_req;
  logic [ADDR_W:0]   save_len;
  logic              overflow;
  logic              busy;

  int                vectors = 0;
  int                errors = 0;
  int                req_cnt = 0;
  int                req_base;
  logic [7:0]        sb_q[$];
  logic [7:0]        mon_exp;
  logic [RD_LAT-1:0] hist = '0;

  ascii_save_capture #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .capture_arm(capture_arm), .tx_wr(tx_wr),
    .tx_data(tx_data), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req),
    .save_len(save_len), .overflow(overflow), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_sys or posedge reset)
    if (reset) hist <= '0;
    else hist <= {hist[RD_LAT-2:0], ioctl_rd};

  always @(posedge clk_sys)
    if (ioctl_upload_req) req_cnt++;

  // Read data must appear exactly RD_LAT cycles after each accepted rd.
  always @(negedge clk_sys)
    if (hist[RD_LAT-1]) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        mon_exp = sb_q.pop_front();
        chk("ioctl_din", ioctl_din, mon_exp);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic tx(input logic [7:0] d);
    tx_wr = 1'b1; tx_data = d;
    cyc(1);
    tx_wr = 1'b0;
  endtask

  task automatic arm(input logic v);
    capture_arm = v;
    cyc(3);
  endtask

  task automatic up(input logic v);
    ioctl_upload = v;
    cyc(2);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    ioctl_addr = a; ioctl_rd = 1'b1;
    sb_q.push_back(e);
    cyc(1);
    ioctl_rd = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_req", ioctl_upload_req, 1'b0);
    chk("rst_len", save_len, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // tx_wr in IDLE is ignored
    tx(8'h99); cyc(2);
    chk("idle_tx_len", save_len, 5'd0);

    // Test 1 + back-to-back reads
    req_base = req_cnt;
    arm(1'b1);
    chk("cap_busy", busy, 1'b1);
    tx(8'h41); tx(8'h42); tx(8'h0D);
    arm(1'b0);
    chk("t1_len", save_len, LF ? 5'd4 : 5'd3);
    chk("t1_req", req_cnt - req_base, 1);
    chk("t1_busy", busy, 1'b0);
    up(1'b1);
    chk("up_busy", busy, 1'b1);
    rd(16'd0, 8'h41); rd(16'd1, 8'h42); rd(16'd2, 8'h0D); rd(16'd3, LF ? 8'h0A : 8'h00);
    rd(16'd1, 8'h42);
    cyc(6);
    chk("t1_hold", ioctl_din, 8'h42);
    up(1'b0);
    chk("t1_len_kept", save_len, LF ? 5'd4 : 5'd3);

    // Test 3: empty capture, tx in HOLD
    req_base = req_cnt;
    arm(1'b1); arm(1'b0);
    chk("t3_len", save_len, 5'd0);
    chk("t3_req", req_cnt - req_base, 0);
    tx(8'h77); cyc(2);
    chk("hold_tx_len", save_len, 5'd0);

    // Test 4: CR immediately followed by another byte
    req_base = req_cnt;
    arm(1'b1);
    tx(8'h0D); tx(8'h55);
    arm(1'b0);
    chk("t4_len", save_len, LF ? 5'd3 : 5'd2);
    chk("t4_req", req_cnt - req_base, 1);
    up(1'b1);
    rd(16'd2, LF ? 8'h55 : 8'h00); rd(16'd1, LF ? 8'h0A : 8'h55); rd(16'd0, 8'h0D);
    cyc(4);
    up(1'b0);

    // Test 2: overflow with DEPTH 16
    arm(1'b1);
    chk("cap_din_zero", ioctl_din, 8'h00);
    for (int i = 0; i < 20; i++) tx(8'h60 + 8'(i));
    cyc(2);
    chk("t2_len", save_len, 5'd16);
    chk("t2_ovf", overflow, 1'b1);
    arm(1'b0);
    up(1'b1);
    rd(16'd15, 8'h6F); rd(16'd16, 8'h00); rd(16'd0, 8'h60);
    cyc(4);
    chk("t2_hold", ioctl_din, 8'h60);

    // Test 5: reset with a read in flight
    ioctl_addr = 16'd15; ioctl_rd = 1'b1;
    cyc(1);
    ioctl_rd = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_din", ioctl_din, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_len", save_len, 5'd0);
    chk("t5_ovf", overflow, 1'b0);
    ioctl_upload = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("t5_din_after", ioctl_din, 8'h00);

    // Fresh capture; last byte coincides with arm fall
    req_base = req_cnt;
    arm(1'b1);
    tx(8'h31);
    tx_wr = 1'b1; tx_data = 8'h32; capture_arm = 1'b0;
    cyc(1);
    tx_wr = 1'b0;
    cyc(3);
    chk("t5_new_len", save_len, 5'd2);
    chk("t5_new_req", req_cnt - req_base, 1);
    chk("t5_new_busy", busy, 1'b0);
    up(1'b1);
    rd(16'd0, 8'h31); rd(16'd1, 8'h32); rd(16'd2, 8'h00);
    cyc(4);
    up(1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
